// File: rtl/array_cmd_issuer.sv
// rtl/array_cmd_issuer.sv - host command sequencer for the array controller
// Expands host burst commands into per-bank beats with MAC-latency and write->read NOP padding.
module array_cmd_issuer #(
  parameter int BANK_W    = 4,
  parameter int WORD_W    = 8,
  parameter int LEN_W     = 4,
  parameter int MAC_LAT   = 4,
  parameter int WR_RD_GAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [BANK_W-1:0] cmd_bank_i,
  input  logic [WORD_W-1:0] cmd_word_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic [1:0]        op_code_o,
  output logic [BANK_W-1:0] bank_sel_o,
  output logic [WORD_W-1:0] word_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [1:0] OP_MAC = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // Wait counters count down to zero; a load of N gives N+1 cycles in the state.
  // The final beat of a MAC burst waits one cycle less: the done cycle is its last NOP.
  localparam logic [3:0] MAC_WAIT_MID  = 4'(MAC_LAT - 2);
  localparam logic [3:0] MAC_WAIT_LAST = 4'(MAC_LAT - 3);
  localparam logic [3:0] GAP_LOAD      = 4'(WR_RD_GAP - 1);

  typedef enum logic [1:0] {IDLE, GAP, ISSUE, MAC_WAIT} state_t;

  state_t              state_q;
  logic [1:0]          cmd_op_q;
  logic [1:0]          last_op_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat_q;
  logic [3:0]          cnt_q;
  logic [1:0]          op_code_q;
  logic [BANK_W-1:0]   bank_sel_q;
  logic [WORD_W-1:0]   word_q;
  logic                busy_q;
  logic                done_q;
  logic                last_beat;

  assign last_beat   = (beat_q == len_q);
  assign cmd_ready_o = (state_q == IDLE);
  assign op_code_o   = op_code_q;
  assign bank_sel_o  = bank_sel_q;
  assign word_o      = word_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_op_q   <= OP_NOP;
      last_op_q  <= OP_NOP;
      len_q      <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
      op_code_q  <= OP_NOP;
      bank_sel_q <= '0;
      word_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            if (cmd_op_i == OP_NOP) begin
              done_q <= 1'b1;
            end else begin
              cmd_op_q   <= cmd_op_i;
              len_q      <= cmd_len_i;
              beat_q     <= '0;
              bank_sel_q <= cmd_bank_i;
              word_q     <= cmd_word_i;
              busy_q     <= 1'b1;
              if (cmd_op_i == OP_RD && last_op_q == OP_WR && WR_RD_GAP > 0) begin
                state_q <= GAP;
                cnt_q   <= GAP_LOAD;
              end else begin
                state_q   <= ISSUE;
                op_code_q <= cmd_op_i;
              end
            end
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_q   <= ISSUE;
            op_code_q <= cmd_op_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ISSUE: begin
          last_op_q <= cmd_op_q;
          if (cmd_op_q == OP_MAC && !last_beat && MAC_LAT > 1) begin
            state_q   <= MAC_WAIT;
            cnt_q     <= MAC_WAIT_MID;
            op_code_q <= OP_NOP;
          end else if (cmd_op_q == OP_MAC && last_beat && MAC_LAT > 2) begin
            state_q   <= MAC_WAIT;
            cnt_q     <= MAC_WAIT_LAST;
            op_code_q <= OP_NOP;
          end else if (last_beat) begin
            state_q   <= IDLE;
            op_code_q <= OP_NOP;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            beat_q     <= beat_q + LEN_W'(1);
            bank_sel_q <= bank_sel_q + BANK_W'(1);
          end
        end
        MAC_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (last_beat) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q    <= ISSUE;
            op_code_q  <= cmd_op_q;
            beat_q     <= beat_q + LEN_W'(1);
            bank_sel_q <= bank_sel_q + BANK_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_cmd_issuer.sv
// tb/tb_array_cmd_issuer.sv - self-checking bench for array_cmd_issuer
// Expected per-cycle output traces are built from each accepted command and compared every cycle.
module tb_array_cmd_issuer;

  localparam int MAC_LAT   = 4;
  localparam int WR_RD_GAP = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [1:0] cmd_op_i = 2'b11;
  logic [3:0] cmd_bank_i = '0;
  logic [7:0] cmd_word_i = '0;
  logic [3:0] cmd_len_i = '0;
  logic [1:0] op_code_o;
  logic [3:0] bank_sel_o;
  logic [7:0] word_o;
  logic       busy_o;
  logic       done_o;

  array_cmd_issuer #(
    .BANK_W(4), .WORD_W(8), .LEN_W(4), .MAC_LAT(MAC_LAT), .WR_RD_GAP(WR_RD_GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_bank_i(cmd_bank_i), .cmd_word_i(cmd_word_i), .cmd_len_i(cmd_len_i),
    .op_code_o(op_code_o), .bank_sel_o(bank_sel_o), .word_o(word_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  int n_done = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] bank;
    logic [7:0] word;
    logic       done;
    logic       busy;
  } rec_t;

  rec_t       exp_q[$];
  rec_t       cur;
  logic [3:0] m_bank;
  logic [7:0] m_word;
  logic [1:0] m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole expected trace of one command, one entry per cycle after the accept edge.
  function automatic void gen(input logic [1:0] op, input logic [3:0] bank,
                              input logic [7:0] word, input logic [3:0] len);
    int nw;
    logic [3:0] b;
    if (op == 2'b11) begin
      exp_q.push_back('{2'b11, m_bank, m_word, 1'b1, 1'b0});
      return;
    end
    if (op == 2'b01 && m_last == 2'b10)
      for (int g = 0; g < WR_RD_GAP; g++) exp_q.push_back('{2'b11, bank, word, 1'b0, 1'b1});
    m_last = op;
    for (int i = 0; i <= int'(len); i++) begin
      b = 4'(int'(bank) + i);
      exp_q.push_back('{op, b, word, 1'b0, 1'b1});
      if (op == 2'b00) begin
        nw = (i == int'(len)) ? MAC_LAT - 2 : MAC_LAT - 1;
        for (int k = 0; k < nw; k++) exp_q.push_back('{2'b11, b, word, 1'b0, 1'b1});
      end
    end
    m_bank = 4'(int'(bank) + int'(len));
    m_word = word;
    exp_q.push_back('{2'b11, m_bank, m_word, 1'b1, 1'b0});
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      m_bank = '0;
      m_word = '0;
      m_last = 2'b11;
      cur = '{2'b11, 4'd0, 8'd0, 1'b0, 1'b0};
    end else begin
      if (!cur.busy && cmd_valid_i) begin
        gen(cmd_op_i, cmd_bank_i, cmd_word_i, cmd_len_i);
        n_acc++;
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = '{2'b11, m_bank, m_word, 1'b0, 1'b0};
    end
  end

  initial forever begin
    @(negedge clk);
    if (done_o === 1'b1) n_done++;
    if (cmp_en) begin
      chk("op_code", 32'(op_code_o), 32'(cur.op));
      chk("bank_sel", 32'(bank_sel_o), 32'(cur.bank));
      chk("word", 32'(word_o), 32'(cur.word));
      chk("done", 32'(done_o), 32'(cur.done));
      chk("busy", 32'(busy_o), 32'(cur.busy));
      chk("cmd_ready", 32'(cmd_ready_o), 32'(!cur.busy));
    end
  end

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] b,
                       input logic [7:0] w, input logic [3:0] l);
    cmd_valid_i = v;
    cmd_op_i    = op;
    cmd_bank_i  = b;
    cmd_word_i  = w;
    cmd_len_i   = l;
  endtask

  task automatic lit(input string nm, input logic [1:0] op, input logic [3:0] bank,
                     input logic [7:0] word, input logic done, input logic busy);
    @(negedge clk);
    chk(nm, 32'({op_code_o, bank_sel_o, word_o, done_o, busy_o}), 32'({op, bank, word, done, busy}));
    chk({nm, "_model"}, 32'({cur.op, cur.bank, cur.word, cur.done, cur.busy}),
        32'({op, bank, word, done, busy}));
  endtask

  task automatic wait_accept();
    int start;
    int k;
    start = n_acc;
    k = 0;
    while (n_acc == start && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("accept_timeout", 32'(n_acc != start), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int r;
    logic [1:0] op;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'({op_code_o, bank_sel_o, word_o, done_o, busy_o, cmd_ready_o}),
        32'({2'b11, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1}));
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Burst wrapping past bank 15.
    sync(); drive(1, 2'b10, 4'd14, 8'hA5, 4'd2);
    lit("t1_b14", 2'b10, 4'd14, 8'hA5, 0, 1); #1 cmd_valid_i = 0;
    lit("t1_b15", 2'b10, 4'd15, 8'hA5, 0, 1);
    lit("t1_b0",  2'b10, 4'd0,  8'hA5, 0, 1);
    lit("t1_done", 2'b11, 4'd0, 8'hA5, 1, 0);
    lit("t1_idle", 2'b11, 4'd0, 8'hA5, 0, 0);

    // Write then read: one turnaround NOP.
    sync(); drive(1, 2'b10, 4'd3, 8'h11, 4'd0);
    lit("t2_wr", 2'b10, 4'd3, 8'h11, 0, 1);
    #1 drive(1, 2'b01, 4'd3, 8'h22, 4'd0);
    lit("t2_wr_done", 2'b11, 4'd3, 8'h11, 1, 0);
    lit("t2_gap", 2'b11, 4'd3, 8'h22, 0, 1); #1 cmd_valid_i = 0;
    lit("t2_rd", 2'b01, 4'd3, 8'h22, 0, 1);
    lit("t2_rd_done", 2'b11, 4'd3, 8'h22, 1, 0);

    // Two MAC beats with latency padding.
    sync(); drive(1, 2'b00, 4'd0, 8'h5A, 4'd1);
    lit("t3_mac0", 2'b00, 4'd0, 8'h5A, 0, 1); #1 cmd_valid_i = 0;
    for (int i = 0; i < 3; i++) lit("t3_wait0", 2'b11, 4'd0, 8'h5A, 0, 1);
    lit("t3_mac1", 2'b00, 4'd1, 8'h5A, 0, 1);
    for (int i = 0; i < 2; i++) lit("t3_wait1", 2'b11, 4'd1, 8'h5A, 0, 1);
    lit("t3_done", 2'b11, 4'd1, 8'h5A, 1, 0);

    // NOP command keeps write history; following read still gets the gap.
    sync(); drive(1, 2'b10, 4'd7, 8'h33, 4'd0);
    lit("t4_wr", 2'b10, 4'd7, 8'h33, 0, 1); #1 cmd_valid_i = 0;
    lit("t4_wr_done", 2'b11, 4'd7, 8'h33, 1, 0);
    sync(); drive(1, 2'b11, 4'd9, 8'h44, 4'd5);
    lit("t4_nop_done", 2'b11, 4'd7, 8'h33, 1, 0); #1 cmd_valid_i = 0;
    lit("t4_nop_idle", 2'b11, 4'd7, 8'h33, 0, 0);
    sync(); drive(1, 2'b01, 4'd8, 8'h55, 4'd0);
    lit("t4_gap", 2'b11, 4'd8, 8'h55, 0, 1); #1 cmd_valid_i = 0;
    lit("t4_rd", 2'b01, 4'd8, 8'h55, 0, 1);
    lit("t4_rd_done", 2'b11, 4'd8, 8'h55, 1, 0);

    // Asynchronous reset mid-burst, then a read with no gap.
    sync(); drive(1, 2'b10, 4'd14, 8'hA5, 4'd2);
    lit("t5_b14", 2'b10, 4'd14, 8'hA5, 0, 1); #1 cmd_valid_i = 0;
    lit("t5_b15", 2'b10, 4'd15, 8'hA5, 0, 1);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_reset", 32'({op_code_o, bank_sel_o, word_o, done_o, busy_o, cmd_ready_o}),
           32'({2'b11, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1}));
    @(negedge clk); #1 rst_n = 1'b1;
    sync(); drive(1, 2'b01, 4'd3, 8'h66, 4'd0);
    lit("t5_rd_nogap", 2'b01, 4'd3, 8'h66, 0, 1); #1 cmd_valid_i = 0;
    lit("t5_rd_done", 2'b11, 4'd3, 8'h66, 1, 0);

    // Valid held high: second copy accepted on the edge after done.
    sync(); d0 = n_done; drive(1, 2'b10, 4'd2, 8'h77, 4'd3);
    for (int i = 0; i < 4; i++) lit("t6_first", 2'b10, 4'(2 + i), 8'h77, 0, 1);
    lit("t6_done1", 2'b11, 4'd5, 8'h77, 1, 0);
    lit("t6_second", 2'b10, 4'd2, 8'h77, 0, 1); #1 cmd_valid_i = 0;
    for (int i = 1; i < 4; i++) lit("t6_second", 2'b10, 4'(2 + i), 8'h77, 0, 1);
    lit("t6_done2", 2'b11, 4'd5, 8'h77, 1, 0);
    #1 chk("t6_done_count", 32'(n_done - d0), 32'd2);

    // Randomized commands, idle gaps, back-to-back holds and occasional resets.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        cmd_valid_i = 0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        #1;
      end
      r = $urandom_range(0, 9);
      op = (r == 0) ? 2'b11 : (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : 2'b10;
      drive(1, op, 4'($urandom), 8'($urandom),
            (op == 2'b00) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15)));
      wait_accept();
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    cmd_valid_i = 0;
    repeat (100) @(negedge clk);
    chk("final_idle", 32'({busy_o, cmd_ready_o, op_code_o}), 32'({1'b0, 1'b1, 2'b11}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
